// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the core-memory arbiter: sequencer states,
// owner codes and the bit positions of the per-requester vectors.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMem  = 2'd1,
        StDone = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnCpu  = 2'd1,
        OwnPnl  = 2'd2,
        OwnBrk  = 2'd3
    } owner_t;

    // Bit positions inside eligibility / winner / ack vectors
    localparam int unsigned WinCpu = 0;
    localparam int unsigned WinPnl = 1;
    localparam int unsigned WinBrk = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selector: CPU lock, then CPU anti-starvation,
// then fixed priority brk > pnl > cpu. Output is one-hot or zero.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BRK = 4,
    parameter int unsigned RUN_W   = 3
) (
    input  logic [2:0]       i_elig,
    input  logic [1:0]       i_owner,
    input  logic             i_cpu_req,
    input  logic             i_cpu_lock,
    input  logic [RUN_W-1:0] i_brk_run,
    output logic [2:0]       o_win
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BRK);

    logic w_lock;

    // A locked CPU keeps the memory across its own ack cycle, so the
    // write half of a read-modify-write cannot be overtaken.
    assign w_lock = (i_owner == OwnCpu) && i_cpu_lock && i_cpu_req;

    // Pick at most one winner
    always_comb begin
        o_win = '0;
        if (w_lock) begin
            o_win[WinCpu] = i_elig[WinCpu];
        end else if ((i_brk_run == RUN_MAX) && i_elig[WinCpu]) begin
            o_win[WinCpu] = 1'b1;
        end else if (i_elig[WinBrk]) begin
            o_win[WinBrk] = 1'b1;
        end else if (i_elig[WinPnl]) begin
            o_win[WinPnl] = 1'b1;
        end else if (i_elig[WinCpu]) begin
            o_win[WinCpu] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Core-memory arbiter: serves CPU, front panel and data-break requests
// one at a time through IDLE -> MEM -> DONE against a synchronous RAM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned MAX_BRK = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_halted,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic              i_cpu_lock,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [0:DATA_W-1] i_cpu_wdata,
    output logic              o_cpu_ack,
    input  logic              i_pnl_req,
    input  logic              i_pnl_we,
    input  logic [ADDR_W-1:0] i_pnl_addr,
    input  logic [0:DATA_W-1] i_pnl_wdata,
    output logic              o_pnl_ack,
    input  logic              i_brk_req,
    input  logic              i_brk_we,
    input  logic [ADDR_W-1:0] i_brk_addr,
    input  logic [0:DATA_W-1] i_brk_wdata,
    output logic              o_brk_ack,
    output logic [0:DATA_W-1] o_rdata,
    output logic [1:0]        o_owner,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [0:DATA_W-1] o_mem_din,
    output logic              o_mem_we,
    input  logic [0:DATA_W-1] i_mem_dout
);

    localparam int unsigned      RUN_W   = $clog2(MAX_BRK + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BRK);

    state_t            r_state, w_state_d;
    owner_t            r_owner, w_owner_d;
    logic [ADDR_W-1:0] r_mem_addr, w_addr_d;
    logic [0:DATA_W-1] r_mem_din, w_din_d;
    logic [0:DATA_W-1] r_rdata, w_rdata_d;
    logic              r_mem_we, w_we_d;
    logic              r_wr, w_wr_d;      // latched write flag, outlives the strobe
    logic [2:0]        r_ack, w_ack_d;
    logic [RUN_W-1:0]  r_brk_run, w_brk_run_d;
    logic [2:0]        w_elig;
    logic [2:0]        w_win;

    // A requester whose ack is showing is not re-served in that cycle
    assign w_elig = {i_brk_req & ~r_ack[WinBrk],
                     i_pnl_req & i_cpu_halted & ~r_ack[WinPnl],
                     i_cpu_req & ~r_ack[WinCpu]};

    mem_arb_pick #(
        .MAX_BRK (MAX_BRK),
        .RUN_W   (RUN_W)
    ) u_pick (
        .i_elig     (w_elig),
        .i_owner    (r_owner),
        .i_cpu_req  (i_cpu_req),
        .i_cpu_lock (i_cpu_lock),
        .i_brk_run  (r_brk_run),
        .o_win      (w_win)
    );

    // Next-state and datapath update for the access sequencer
    always_comb begin
        w_state_d   = r_state;
        w_owner_d   = r_owner;
        w_addr_d    = r_mem_addr;
        w_din_d     = r_mem_din;
        w_we_d      = r_mem_we;
        w_wr_d      = r_wr;
        w_rdata_d   = r_rdata;
        w_ack_d     = '0;
        w_brk_run_d = r_brk_run;
        case (r_state)
            StIdle: begin
                if (!i_cpu_req) begin
                    w_brk_run_d = '0;
                end
                if (|w_win) begin
                    w_state_d = StMem;
                    unique case (1'b1)
                        w_win[WinBrk]: begin
                            w_owner_d = OwnBrk;
                            w_addr_d  = i_brk_addr;
                            w_din_d   = i_brk_wdata;
                            w_we_d    = i_brk_we;
                            w_wr_d    = i_brk_we;
                            if (i_cpu_req && (r_brk_run != RUN_MAX)) begin
                                w_brk_run_d = r_brk_run + RUN_W'(1);
                            end
                        end
                        w_win[WinPnl]: begin
                            w_owner_d = OwnPnl;
                            w_addr_d  = i_pnl_addr;
                            w_din_d   = i_pnl_wdata;
                            w_we_d    = i_pnl_we;
                            w_wr_d    = i_pnl_we;
                        end
                        w_win[WinCpu]: begin
                            w_owner_d   = OwnCpu;
                            w_addr_d    = i_cpu_addr;
                            w_din_d     = i_cpu_wdata;
                            w_we_d      = i_cpu_we;
                            w_wr_d      = i_cpu_we;
                            w_brk_run_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            StMem: begin
                w_we_d    = 1'b0;
                w_state_d = StDone;
            end
            StDone: begin
                if (!r_wr) begin
                    w_rdata_d = i_mem_dout;
                end
                case (r_owner)
                    OwnCpu:  w_ack_d[WinCpu] = 1'b1;
                    OwnPnl:  w_ack_d[WinPnl] = 1'b1;
                    OwnBrk:  w_ack_d[WinBrk] = 1'b1;
                    default: ;
                endcase
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any access in flight
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_owner    <= OwnNone;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_wr       <= 1'b0;
            r_rdata    <= '0;
            r_ack      <= '0;
            r_brk_run  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_owner    <= w_owner_d;
            r_mem_addr <= w_addr_d;
            r_mem_din  <= w_din_d;
            r_mem_we   <= w_we_d;
            r_wr       <= w_wr_d;
            r_rdata    <= w_rdata_d;
            r_ack      <= w_ack_d;
            r_brk_run  <= w_brk_run_d;
        end
    end

    assign o_cpu_ack  = r_ack[WinCpu];
    assign o_pnl_ack  = r_ack[WinPnl];
    assign o_brk_ack  = r_ack[WinBrk];
    assign o_rdata    = r_rdata;
    assign o_owner    = r_owner;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_din  = r_mem_din;
    assign o_mem_we   = r_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
// Acks are logged per cycle (who, cycle, rdata) and compared against
// hand-computed service tables.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 12;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_cpu_halted;
    logic              i_cpu_req, i_cpu_we, i_cpu_lock;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [0:DATA_W-1] i_cpu_wdata;
    logic              o_cpu_ack;
    logic              i_pnl_req, i_pnl_we;
    logic [ADDR_W-1:0] i_pnl_addr;
    logic [0:DATA_W-1] i_pnl_wdata;
    logic              o_pnl_ack;
    logic              i_brk_req, i_brk_we;
    logic [ADDR_W-1:0] i_brk_addr;
    logic [0:DATA_W-1] i_brk_wdata;
    logic              o_brk_ack;
    logic [0:DATA_W-1] o_rdata;
    logic [1:0]        o_owner;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [0:DATA_W-1] o_mem_din;
    logic              o_mem_we;
    logic [0:DATA_W-1] mem_dout;

    // Behavioural RAM with a preload port so only one process writes it
    logic [0:DATA_W-1] ram [0:32767];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [0:DATA_W-1] pl_data = '0;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    int          log_who[$];
    int          log_cyc[$];
    logic [11:0] log_dat[$];
    int          exp_who[$];
    int          exp_dcyc[$];
    int          we_cnt;
    logic [14:0] we_addr;
    logic [11:0] we_din;
    logic        drop_cpu, drop_pnl, drop_brk;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (o_mem_we) ram[o_mem_addr] <= o_mem_din;
        mem_dout <= ram[o_mem_addr];
    end

    mem_arbiter dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_cpu_halted (i_cpu_halted),
        .i_cpu_req    (i_cpu_req),
        .i_cpu_we     (i_cpu_we),
        .i_cpu_lock   (i_cpu_lock),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_wdata  (i_cpu_wdata),
        .o_cpu_ack    (o_cpu_ack),
        .i_pnl_req    (i_pnl_req),
        .i_pnl_we     (i_pnl_we),
        .i_pnl_addr   (i_pnl_addr),
        .i_pnl_wdata  (i_pnl_wdata),
        .o_pnl_ack    (o_pnl_ack),
        .i_brk_req    (i_brk_req),
        .i_brk_we     (i_brk_we),
        .i_brk_addr   (i_brk_addr),
        .i_brk_wdata  (i_brk_wdata),
        .o_brk_ack    (o_brk_ack),
        .o_rdata      (o_rdata),
        .o_owner      (o_owner),
        .o_mem_addr   (o_mem_addr),
        .o_mem_din    (o_mem_din),
        .o_mem_we     (o_mem_we),
        .i_mem_dout   (mem_dout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [14:0] a, input logic [11:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic clear_log();
        log_who.delete();
        log_cyc.delete();
        log_dat.delete();
        exp_who.delete();
        exp_dcyc.delete();
        we_cnt = 0;
    endtask

    // Advance n cycles, sampling on the falling edge and applying drop policy
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_brk_ack) begin log_who.push_back(3); log_cyc.push_back(cyc); log_dat.push_back(o_rdata); end
            if (o_pnl_ack) begin log_who.push_back(2); log_cyc.push_back(cyc); log_dat.push_back(o_rdata); end
            if (o_cpu_ack) begin log_who.push_back(1); log_cyc.push_back(cyc); log_dat.push_back(o_rdata); end
            if (o_mem_we) begin
                we_cnt++;
                we_addr = o_mem_addr;
                we_din  = o_mem_din;
            end
            if (o_cpu_ack && drop_cpu) i_cpu_req = 1'b0;
            if (o_pnl_ack && drop_pnl) i_pnl_req = 1'b0;
            if (o_brk_ack && drop_brk) i_brk_req = 1'b0;
        end
    endtask

    task automatic expect_ack(input int who, input int dcyc);
        exp_who.push_back(who);
        exp_dcyc.push_back(dcyc);
    endtask

    task automatic check_seq(input string tag, input int t0);
        check_eq({tag, "_count"}, log_who.size(), exp_who.size());
        for (int i = 0; i < exp_who.size(); i++) begin
            if (i < log_who.size()) begin
                check_eq($sformatf("%s_who%0d", tag, i), log_who[i], exp_who[i]);
                check_eq($sformatf("%s_cyc%0d", tag, i), log_cyc[i] - t0, exp_dcyc[i]);
            end
        end
    endtask

    task automatic check_dat(input string tag, input int idx, input logic [11:0] exp);
        if (idx < log_dat.size()) check_eq(tag, log_dat[idx], exp);
        else check_eq({tag, "_missing"}, 0, 1);
    endtask

    initial begin
        int t0;
        i_reset = 1'b0;
        i_cpu_halted = 1'b0;
        i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_lock = 1'b0;
        i_cpu_addr = '0;  i_cpu_wdata = '0;
        i_pnl_req = 1'b0; i_pnl_we = 1'b0; i_pnl_addr = '0; i_pnl_wdata = '0;
        i_brk_req = 1'b0; i_brk_we = 1'b0; i_brk_addr = '0; i_brk_wdata = '0;
        drop_cpu = 1'b1; drop_pnl = 1'b1; drop_brk = 1'b1;
        clear_log();

        // Reset state, with RAM preloads done while held
        preload(15'o00200, 12'o7402);
        preload(15'o00300, 12'o1111);
        preload(15'o00301, 12'o2222);
        preload(15'o00010, 12'o7777);
        preload(15'o00400, 12'o0055);
        preload(15'o00500, 12'o1111);
        check_eq("rst_acks", {o_cpu_ack, o_pnl_ack, o_brk_ack}, 0);
        check_eq("rst_we", o_mem_we, 0);
        check_eq("rst_addr", o_mem_addr, 0);
        check_eq("rst_din", o_mem_din, 0);
        check_eq("rst_rdata", o_rdata, 0);
        check_eq("rst_owner", o_owner, 0);
        i_reset = 1'b1;
        run_cycles(2);

        // Single CPU read
        clear_log();
        t0 = cyc;
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 15'o00200;
        run_cycles(8);
        expect_ack(1, 3);
        check_seq("cpu_rd", t0);
        check_dat("cpu_rd_data", 0, 12'o7402);
        check_eq("cpu_rd_we", we_cnt, 0);
        check_eq("cpu_rd_owner", o_owner, 1);

        // Panel deposit while halted
        clear_log();
        t0 = cyc;
        i_cpu_halted = 1'b1;
        i_pnl_req = 1'b1; i_pnl_we = 1'b1; i_pnl_addr = 15'o00000; i_pnl_wdata = 12'o5201;
        run_cycles(8);
        expect_ack(2, 3);
        check_seq("pnl_dep", t0);
        check_eq("pnl_dep_we", we_cnt, 1);
        check_eq("pnl_dep_addr", we_addr, 0);
        check_eq("pnl_dep_din", we_din, 12'o5201);
        check_eq("pnl_dep_ram", ram[0], 12'o5201);

        // Same deposit with the CPU running is ignored
        clear_log();
        i_cpu_halted = 1'b0;
        i_pnl_req = 1'b1; i_pnl_wdata = 12'o6666;
        run_cycles(8);
        check_eq("pnl_run_acks", log_who.size(), 0);
        check_eq("pnl_run_we", we_cnt, 0);
        i_pnl_req = 1'b0; i_pnl_we = 1'b0;
        run_cycles(1);

        // Three at once: brk, pnl, cpu, three clocks apart
        clear_log();
        t0 = cyc;
        i_cpu_halted = 1'b1;
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 15'o00300;
        i_pnl_req = 1'b1; i_pnl_we = 1'b0; i_pnl_addr = 15'o00301;
        i_brk_req = 1'b1; i_brk_we = 1'b1; i_brk_addr = 15'o00302; i_brk_wdata = 12'o1234;
        run_cycles(14);
        expect_ack(3, 3); expect_ack(2, 6); expect_ack(1, 9);
        check_seq("all3", t0);
        check_dat("all3_brk_hold", 0, 12'o7402);
        check_dat("all3_pnl_data", 1, 12'o2222);
        check_dat("all3_cpu_data", 2, 12'o1111);
        check_eq("all3_ram", ram[15'o00302], 12'o1234);

        // Lone brk held: the CPU takes the brk ack cycle
        clear_log();
        t0 = cyc;
        drop_brk = 1'b0;
        i_cpu_req = 1'b1; i_cpu_addr = 15'o00200;
        i_brk_req = 1'b1; i_brk_we = 1'b0; i_brk_addr = 15'o00300;
        run_cycles(13);
        i_brk_req = 1'b0;
        run_cycles(3);
        expect_ack(3, 3); expect_ack(1, 6); expect_ack(3, 9); expect_ack(3, 13);
        check_seq("brk_hold", t0);

        // brk and pnl alternate; after 4 brk grants the CPU must get in
        clear_log();
        t0 = cyc;
        drop_pnl = 1'b0;
        i_cpu_req = 1'b1; i_cpu_addr = 15'o00010;
        i_pnl_req = 1'b1; i_pnl_addr = 15'o00301;
        i_brk_req = 1'b1; i_brk_addr = 15'o00300;
        run_cycles(27);
        i_brk_req = 1'b0; i_pnl_req = 1'b0;
        run_cycles(3);
        expect_ack(3, 3);  expect_ack(2, 6);  expect_ack(3, 9);  expect_ack(2, 12);
        expect_ack(3, 15); expect_ack(2, 18); expect_ack(3, 21); expect_ack(1, 24);
        expect_ack(3, 27);
        check_seq("starve", t0);
        check_dat("starve_cpu_data", 7, 12'o7777);
        drop_pnl = 1'b1; drop_brk = 1'b1;

        // ISZ: locked read then write, brk waits until the lock drops
        clear_log();
        t0 = cyc;
        drop_cpu = 1'b0;
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_lock = 1'b1; i_cpu_addr = 15'o00010;
        run_cycles(1);
        i_brk_req = 1'b1; i_brk_we = 1'b0; i_brk_addr = 15'o00400;
        run_cycles(2);
        i_cpu_we = 1'b1; i_cpu_wdata = 12'o0000;
        run_cycles(4);
        i_cpu_req = 1'b0; i_cpu_lock = 1'b0; i_cpu_we = 1'b0;
        run_cycles(6);
        expect_ack(1, 3); expect_ack(1, 7); expect_ack(3, 10);
        check_seq("isz", t0);
        check_dat("isz_rd_data", 0, 12'o7777);
        check_dat("isz_brk_data", 2, 12'o0055);
        check_eq("isz_ram", ram[15'o00010], 12'o0000);
        drop_cpu = 1'b1;

        // Reset while a CPU write is in MEM
        clear_log();
        t0 = cyc;
        i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 15'o00500; i_cpu_wdata = 12'o4321;
        run_cycles(1);
        check_eq("rmid_we_pre", o_mem_we, 1);
        i_reset = 1'b0;
        #1;
        check_eq("rmid_we", o_mem_we, 0);
        check_eq("rmid_owner", o_owner, 0);
        check_eq("rmid_acks", {o_cpu_ack, o_pnl_ack, o_brk_ack}, 0);
        check_eq("rmid_addr", o_mem_addr, 0);
        run_cycles(1);
        check_eq("rmid_ram_kept", ram[15'o00500], 12'o1111);
        i_reset = 1'b1;
        run_cycles(8);
        expect_ack(1, 5);
        check_seq("rmid", t0);
        check_eq("rmid_we_cnt", we_cnt, 2);
        check_eq("rmid_ram", ram[15'o00500], 12'o4321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
